// File: rtl/mm_pcpi_pkg.sv
// Shared constants, address map and FSM state type for the PCPI matrix-multiply sequencer.
package mm_pcpi_pkg;

    localparam int N      = 3;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    localparam logic [6:0] CUSTOM0_OPCODE = 7'b0001011;

    localparam logic [2:0] F3_WRITE = 3'b000;
    localparam logic [2:0] F3_CLEAR = 3'b101;
    localparam logic [2:0] F3_RUN   = 3'b111;
    localparam logic [2:0] F3_READ  = 3'b110;

    localparam int A_BASE    = 0;
    localparam int B_BASE    = 9;
    localparam int BIAS_BASE = 18;
    localparam int THR_ADDR  = 27;

    localparam int RUN_STEPS = 7;

    localparam logic signed [DATA_W-1:0] THR_RESET = -16'sd70;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_RUN,
        S_CAPT,
        S_DONE,
        S_RELEASE
    } seq_state_t;

endpackage

// File: rtl/mm_pcpi_sequencer_thresh.sv
// mm_thresh_pack: signed compare of each accumulator against the sign-extended threshold.
module mm_thresh_pack #(
    parameter int N      = 3,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic [N*N*ACC_W-1:0] arr_c,
    input  logic [DATA_W-1:0]    thr,
    output logic [N*N-1:0]       mask
);
    import mm_pcpi_pkg::*;

    logic signed [ACC_W-1:0] thr_ext;

    assign thr_ext = {{(ACC_W-DATA_W){thr[DATA_W-1]}}, thr};

    always_comb begin
        mask = '0;
        for (int unsigned k = 0; k < N*N; k++) begin
            mask[k] = $signed(arr_c[k*ACC_W +: ACC_W]) >= thr_ext;
        end
    end

endmodule

// File: rtl/mm_pcpi_sequencer.sv
// PCPI-side controller for the 3x3 systolic matrix-multiply coprocessor.
// Defining MM_PCPI_SEQ_RAW_READ_EN adds raw accumulator capture and the READ (funct3 110) instruction.
module mm_pcpi_sequencer #(
    parameter int N      = 3,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pcpi_valid,
    input  logic [31:0]          pcpi_insn,
    output logic                 pcpi_wr,
    output logic [31:0]          pcpi_rd,
    output logic                 pcpi_wait,
    output logic                 pcpi_ready,
    output logic                 cfg_we,
    output logic [4:0]           cfg_addr,
    output logic [DATA_W-1:0]    cfg_data,
    output logic [DATA_W-1:0]    thr,
    output logic                 arr_en,
    output logic [2:0]           arr_step,
    output logic                 arr_bias_sel,
    input  logic [N*N*ACC_W-1:0] arr_c
);
    import mm_pcpi_pkg::*;

    seq_state_t state_q, state_d;

    logic [6:0]        opcode;
    logic [4:0]        addr;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] imm;
    logic              unused_insn_bit;

    logic is_custom0, is_write, is_clear, is_run, is_read, claim;

    logic [2:0]        step_q;
    logic [DATA_W-1:0] thr_q;
    logic [N*N-1:0]    mask_q;
    logic [N*N-1:0]    mask_c;
    logic [31:0]       resp_rd_q;
    logic              resp_wr_q;
    logic              cfg_we_q;
    logic [4:0]        cfg_addr_q;
    logic [DATA_W-1:0] cfg_data_q;

`ifdef MM_PCPI_SEQ_RAW_READ_EN
    logic [ACC_W-1:0] raw_q [N*N];
`endif

    assign opcode          = pcpi_insn[6:0];
    assign addr            = pcpi_insn[11:7];
    assign funct3          = pcpi_insn[14:12];
    assign imm             = pcpi_insn[15 +: DATA_W];
    assign unused_insn_bit = pcpi_insn[31];

    always_comb begin
        is_custom0 = pcpi_valid && (opcode == CUSTOM0_OPCODE);
        is_write   = is_custom0 && (funct3 == F3_WRITE);
        is_clear   = is_custom0 && (funct3 == F3_CLEAR);
        is_run     = is_custom0 && (funct3 == F3_RUN);
`ifdef MM_PCPI_SEQ_RAW_READ_EN
        is_read    = is_custom0 && (funct3 == F3_READ);
`else
        is_read    = 1'b0;
`endif
        claim      = is_write || is_clear || is_run || is_read;
    end

    mm_thresh_pack #(
        .N      (N),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_thresh (
        .arr_c (arr_c),
        .thr   (thr_q),
        .mask  (mask_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (is_run)     state_d = S_RUN;
                else if (claim) state_d = S_ACK;
            end
            S_ACK:     state_d = S_RELEASE;
            S_RUN:     if (step_q == 3'(RUN_STEPS - 1)) state_d = S_CAPT;
            S_CAPT:    state_d = S_DONE;
            S_DONE:    state_d = S_RELEASE;
            S_RELEASE: if (!pcpi_valid) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Responses are driven from registered state so a held pcpi_valid cannot retrigger them.
    always_comb begin
        pcpi_ready   = (state_q == S_ACK) || (state_q == S_DONE);
        pcpi_wr      = 1'b0;
        pcpi_rd      = '0;
        if (state_q == S_ACK) begin
            pcpi_wr = resp_wr_q;
            pcpi_rd = resp_rd_q;
        end else if (state_q == S_DONE) begin
            pcpi_wr = 1'b1;
            pcpi_rd = {{(32-N*N){1'b0}}, mask_q};
        end
        pcpi_wait    = claim && !((state_q == S_ACK) || (state_q == S_DONE) || (state_q == S_RELEASE));
        arr_en       = (state_q == S_RUN);
        arr_step     = step_q;
        arr_bias_sel = arr_en && (step_q == 3'd0);
        cfg_we       = cfg_we_q;
        cfg_addr     = cfg_addr_q;
        cfg_data     = cfg_data_q;
        thr          = thr_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            thr_q      <= DATA_W'(THR_RESET);
            mask_q     <= '0;
            resp_rd_q  <= '0;
            resp_wr_q  <= 1'b0;
            cfg_we_q   <= 1'b0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
`ifdef MM_PCPI_SEQ_RAW_READ_EN
            for (int unsigned k = 0; k < N*N; k++) raw_q[k] <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cfg_we_q <= 1'b0;
            step_q   <= (state_q == S_RUN && state_d == S_RUN) ? step_q + 3'd1 : '0;

            if (state_q == S_IDLE) begin
                if (is_write) begin
                    resp_wr_q <= 1'b0;
                    resp_rd_q <= '0;
                    if (addr < 5'(THR_ADDR)) begin
                        cfg_we_q   <= 1'b1;
                        cfg_addr_q <= addr;
                        cfg_data_q <= imm;
                    end else if (addr == 5'(THR_ADDR)) begin
                        thr_q <= imm;
                    end
                end
                if (is_clear) begin
                    resp_wr_q <= 1'b0;
                    resp_rd_q <= '0;
                    mask_q    <= '0;
`ifdef MM_PCPI_SEQ_RAW_READ_EN
                    for (int unsigned k = 0; k < N*N; k++) raw_q[k] <= '0;
`endif
                end
`ifdef MM_PCPI_SEQ_RAW_READ_EN
                if (is_read) begin
                    resp_wr_q <= 1'b1;
                    resp_rd_q <= (addr < 5'(N*N)) ? 32'(raw_q[addr[3:0]]) : '0;
                end
`endif
            end

            if (state_q == S_CAPT) begin
                mask_q <= mask_c;
`ifdef MM_PCPI_SEQ_RAW_READ_EN
                for (int unsigned k = 0; k < N*N; k++) raw_q[k] <= arr_c[k*ACC_W +: ACC_W];
`endif
            end
        end
    end

endmodule

// File: doc/mm_pcpi_sequencer.md
# mm_pcpi_sequencer

PCPI-side controller for the 3x3 systolic matrix-multiply-with-bias coprocessor. It decodes custom-0 instructions from the PicoRV32 co-processor interface and writes operands into the A/B/bias store. It owns the threshold register and sequences the systolic array through its skewed feed steps. It then captures the 9 accumulators, thresholds them, and returns a packed bit-mask to the core.

## Interface
- `N`, 3: array dimension; the only supported value is 3.
- `DATA_W`, 16: operand/bias/threshold width, signed.
- `ACC_W`, 32: accumulator width, signed.
- `clk` in 1: clock.
- `resetn` in 1: reset; synchronous, active-low.
- `pcpi_valid` in 1: instruction offered by the core.
- `pcpi_insn` in 32: instruction word; opcode [6:0], addr [11:7], funct3 [14:12], imm [30:15].
- `pcpi_wr` out 1: write `pcpi_rd` to rd; valid with `pcpi_ready`.
- `pcpi_rd` out 32: result.
- `pcpi_wait` out 1: instruction claimed, not yet done.
- `pcpi_ready` out 1: one-cycle completion pulse.
- `cfg_we` out 1: operand-store write strobe.
- `cfg_addr` out 5: operand-store address, 0–26.
- `cfg_data` out 16: operand-store data.
- `thr` out 16: current threshold, signed.
- `arr_en` out 1: advance the systolic array by one step.
- `arr_step` out 3: feed-skew step index, 0–6.
- `arr_bias_sel` out 1: PEs load bias as c_in; high at step 0 only.
- `arr_c` in N*N*ACC_W: accumulators, element [i][j] at bits (3i+j)*ACC_W.

## Operation
- An instruction is claimed when `pcpi_valid`, opcode == 7'b0001011, and funct3 ∈ {000, 101, 111}. The set also includes 110 when `MM_PCPI_SEQ_RAW_READ_EN` is defined. Any other funct3 is never claimed: wait and ready stay 0, and the core traps.
- WRITE (000): addr 0–26 pulses `cfg_we` for one cycle with `cfg_addr`=addr and `cfg_data`=imm. Addr 27 loads `thr`. Addr 28–31 is a no-op. Response: `pcpi_wr`=0, `pcpi_rd`=0.
- CLEAR (101): zeros the result mask and the raw capture. Response: `pcpi_wr`=0.
- RUN (111): steps 0..6 with `arr_en`=1 and `arr_step`=step. Then CAPT computes mask bit 3i+j = (arr_c[i][j] >= sign-extended thr). Response: `pcpi_wr`=1, `pcpi_rd`={23'b0, mask}.
- FSM states: IDLE, ACK, RUN, CAPT, DONE, RELEASE.
  - IDLE: WRITE or CLEAR goes to ACK; RUN goes to RUN.
  - ACK → RELEASE.
  - RUN → CAPT after step 6.
  - CAPT → DONE.
  - DONE → RELEASE.
  - RELEASE → IDLE once `pcpi_valid` is sampled low. A `pcpi_valid` held high after a response must not re-issue the instruction.
- `pcpi_wait` = claim-decode && state ∉ {ACK, DONE, RELEASE}. It is combinational.
- `pcpi_ready` is high only in ACK and DONE.
- The comparison is signed ACC_W. `thr` is sign-extended from 16 bits.

## Timing
- Reset values: all PCPI outputs 0; `cfg_*` 0; `arr_en` 0; `arr_step` 0; `arr_bias_sel` 0; `thr` = −70 (16'hFFBA); mask 0; state IDLE.
- WRITE/CLEAR accepted at edge k: `cfg_we` is high during cycle k+1, and `pcpi_ready` is high during cycle k+1.
- RUN accepted at edge k: `arr_en` is high in cycles k+1..k+7, with `arr_step` = 0..6. CAPT samples `arr_c` in cycle k+8. `pcpi_ready` and `pcpi_wr` are high in cycle k+9. Latency is 9 cycles, which is below PicoRV32's 16-cycle timeout.
- `arr_step` holds 0 outside RUN.
- `resetn` low in any state takes effect at the next edge: state goes to IDLE, `arr_en` drops, `thr` returns to −70, and no ready is issued for the aborted instruction.
- Writes are only accepted from IDLE, so operand writes never overlap a RUN.

## Configuration
- `MM_PCPI_SEQ_RAW_READ_EN` defined:
  - CAPT also latches all 9 raw accumulators.
  - funct3 110 (READ) is claimed. Addr 0–8 returns raw[addr] with `pcpi_wr`=1 and the ACK timing. Addr ≥9 returns 0.
  - CLEAR zeros the raw registers.
- Undefined: no raw registers, and funct3 110 is unclaimed.

## Structure
- Package `mm_pcpi_pkg` holds:
  - `CUSTOM0_OPCODE`.
  - funct3 codes: `F3_WRITE`, `F3_CLEAR`, `F3_RUN`, `F3_READ`.
  - Address map: `A_BASE`=0, `B_BASE`=9, `BIAS_BASE`=18, `THR_ADDR`=27.
  - `N`, `DATA_W`, `ACC_W`.
  - `RUN_STEPS`=7.
  - `THR_RESET`=−70.
  - The FSM state enum.
- Sub-module `mm_thresh_pack`: combinational compare of 9 accumulators against `thr`, producing the 9-bit mask.

## Test plan
- WRITE addr 4, imm 5 → `cfg_we` high for one cycle with `cfg_addr`=4 and `cfg_data`=5; ready at k+1; `pcpi_wr`=0.
- WRITE addr 27, imm 16'hFFF6 → `thr`=−10; `cfg_we` never asserts.
- RUN with all `arr_c`=100 except [0][0]=−11, `thr`=−10 → `arr_en` high for exactly 7 cycles; `arr_bias_sel` only at step 0; ready at k+9 with `pcpi_rd`=0x1FE and `pcpi_wr`=1.
- `pcpi_valid` held high 5 cycles after a RUN ready → no second `arr_en` burst; a new RUN is accepted only after one low cycle.
- `resetn` low during step 3 → `arr_en`=0 next cycle, `thr`=−70, no `pcpi_ready`; funct3 010 → wait and ready stay 0 for 20 cycles.
- With macro: RUN, then READ addr 0 → `pcpi_rd`=0xFFFFFFF5 and `pcpi_wr`=1; after CLEAR, READ addr 0 → 0.
